// File: rtl/regfile_writeback_pkg.sv
// Shared types and widths for the register-file writeback path.
package regfile_writeback_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  localparam int unsigned ENTRY_W = $bits(wb_entry_t);

  function automatic wb_entry_t make_entry(input logic [REG_W-1:0]  rd,
                                           input logic [DATA_W-1:0] data);
    wb_entry_t e;
    e.rd   = rd;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// ALU/load offer handshakes and register-file write port of the writeback block.
interface regfile_writeback_if #(parameter int unsigned DEPTH = 4);
  import regfile_writeback_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic [REG_W-1:0]  alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [REG_W-1:0]  mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic [DATA_W-1:0] PW;
  logic [REG_W-1:0]  RW;
  logic              LE;
  logic [CNT_W-1:0]  count;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, PW, RW, LE, count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, PW, RW, LE, count
  );

endinterface

// File: rtl/regfile_writeback_wb_fifo.sv
// Writeback queue: up to two pushes (port 0 first) and one pop per cycle.
module wb_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = ENTRY_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push0_i,
  input  logic [WIDTH-1:0]           data0_i,
  input  logic                       push1_i,
  input  logic [WIDTH-1:0]           data1_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d, wptr1_c;
  logic [CW-1:0]    count_q, count_d;

  // Second push lands just behind the first one.
  assign wptr1_c = wptr_q + AW'(push0_i);
  assign wptr_d  = wptr_q + AW'(push0_i) + AW'(push1_i);
  assign rptr_d  = rptr_q + AW'(pop_i);
  assign count_d = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);

  always_ff @(posedge clk) begin
    if (push0_i) mem_q[wptr_q]  <= data0_i;
    if (push1_i) mem_q[wptr1_c] <= data1_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Register-file writer: arbitrates ALU/load results into a FIFO drained onto PW/RW/LE.
// Define REGFILE_WB_G0_DROP_EN to accept but discard writes to register 0.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  regfile_writeback_if.slave  wb
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]  count_c, free_c;
  logic              mem_live_c, mem_keep_c, alu_keep_c;
  logic              mem_acc_c, alu_acc_c, push0_c, push1_c, pop_c;
  wb_entry_t         mem_entry_c, alu_entry_c, push0_data_c, head_c;
  logic [DATA_W-1:0] pw_q;
  logic [REG_W-1:0]  rw_q;
  logic              le_q;

  assign free_c = CNT_W'(DEPTH) - count_c;

`ifdef REGFILE_WB_G0_DROP_EN
  assign mem_keep_c = (wb.mem_rd != '0);
  assign alu_keep_c = (wb.alu_rd != '0);
`else
  assign mem_keep_c = 1'b1;
  assign alu_keep_c = 1'b1;
`endif

  // A load offer that will be dropped does not reserve a slot against the ALU.
  assign mem_live_c   = wb.mem_valid && mem_keep_c;
  assign wb.mem_ready = (free_c >= CNT_W'(1));
  assign wb.alu_ready = mem_live_c ? (free_c >= CNT_W'(2)) : (free_c >= CNT_W'(1));

  assign mem_acc_c   = wb.mem_valid && wb.mem_ready && mem_keep_c;
  assign alu_acc_c   = wb.alu_valid && wb.alu_ready && alu_keep_c;
  assign mem_entry_c = make_entry(wb.mem_rd, wb.mem_data);
  assign alu_entry_c = make_entry(wb.alu_rd, wb.alu_data);
  assign pop_c       = (count_c != '0);

  always_comb begin
    push0_c      = 1'b0;
    push1_c      = 1'b0;
    push0_data_c = alu_entry_c;
    if (mem_acc_c) begin
      push0_c      = 1'b1;
      push0_data_c = mem_entry_c;
      push1_c      = alu_acc_c;
    end else begin
      push0_c      = alu_acc_c;
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push0_i (push0_c),
    .data0_i (push0_data_c),
    .push1_i (push1_c),
    .data1_i (alu_entry_c),
    .pop_i   (pop_c),
    .data_o  (head_c),
    .count_o (count_c)
  );

  // Register-file write port; PW/RW hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pw_q <= '0;
      rw_q <= '0;
      le_q <= 1'b0;
    end else begin
      le_q <= pop_c;
      if (pop_c) begin
        pw_q <= head_c.data;
        rw_q <= head_c.rd;
      end
    end
  end

  assign wb.PW    = pw_q;
  assign wb.RW    = rw_q;
  assign wb.LE    = le_q;
  assign wb.count = count_c;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback (DEPTH=4) with a small queue model.
module tb_regfile_writeback;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  regfile_writeback_if #(.DEPTH(4)) wb_if ();

  regfile_writeback #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb_if)
  );

  int errors = 0;
  int checks = 0;

  logic [36:0] exp_q[$];
  int          mc;
  logic [31:0] last_pw;
  logic [4:0]  last_rw;
  int          writes;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    mc      = 0;
    last_pw = '0;
    last_rw = '0;
  endtask

  // One cycle: drive offers, check readies, clock, check write port and count.
  task automatic step(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                      input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      output logic macc, output logic aacc);
    int          free;
    logic        pop;
    logic [36:0] head;
    wb_if.mem_valid = mv;
    wb_if.mem_rd    = mrd;
    wb_if.mem_data  = md;
    wb_if.alu_valid = av;
    wb_if.alu_rd    = ard;
    wb_if.alu_data  = ad;
    #1;
    free = 4 - mc;
    check("mem_ready", 64'(wb_if.mem_ready), 64'(free >= 1));
    check("alu_ready", 64'(wb_if.alu_ready), 64'(mv ? (free >= 2) : (free >= 1)));
    macc = mv && (free >= 1);
    aacc = av && (mv ? (free >= 2) : (free >= 1));
    pop  = (mc > 0);
    head = '0;
    if (pop) head = exp_q.pop_front();
    if (macc) exp_q.push_back({mrd, md});
    if (aacc) exp_q.push_back({ard, ad});
    mc = mc + int'(macc) + int'(aacc) - int'(pop);
    @(posedge clk);
    #1;
    check("LE", 64'(wb_if.LE), 64'(pop));
    if (pop) begin
      last_rw = head[36:32];
      last_pw = head[31:0];
      writes++;
    end
    check("RW", 64'(wb_if.RW), 64'(last_rw));
    check("PW", 64'(wb_if.PW), 64'(last_pw));
    check("count", 64'(wb_if.count), 64'(mc));
  endtask

  task automatic idle();
    logic ma, aa;
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ma, aa);
  endtask

  initial begin
    logic ma, aa;
    int   mi, ai;

    reset = 1'b0;
    wb_if.alu_valid = 1'b0; wb_if.alu_rd = '0; wb_if.alu_data = '0;
    wb_if.mem_valid = 1'b0; wb_if.mem_rd = '0; wb_if.mem_data = '0;
    clear_model();
    writes = 0;

    // Reset state, asserted between clock edges.
    #1 reset = 1'b1;
    #1;
    check("rst_count", 64'(wb_if.count), 64'd0);
    check("rst_LE", 64'(wb_if.LE), 64'd0);
    check("rst_PW", 64'(wb_if.PW), 64'd0);
    check("rst_RW", 64'(wb_if.RW), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rel_mem_ready", 64'(wb_if.mem_ready), 64'd1);
    check("rel_alu_ready", 64'(wb_if.alu_ready), 64'd1);
    @(posedge clk);
    #1;

    // Single ALU write: LE exactly two edges after acceptance, for one cycle.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, ma, aa);
    check("t34_acc", 64'(aa), 64'd1);
    idle();
    check("t34_LE", 64'(wb_if.LE), 64'd1);
    check("t34_RW", 64'(wb_if.RW), 64'd5);
    check("t34_PW", 64'(wb_if.PW), 64'hDEADBEEF);
    idle();
    check("t34_LE_off", 64'(wb_if.LE), 64'd0);

    // Simultaneous offers to the same register: load first, then ALU.
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, ma, aa);
    idle();
    check("t35_first", 64'(wb_if.PW), 64'h11);
    idle();
    check("t35_second", 64'(wb_if.PW), 64'h22);
    check("t35_rw", 64'(wb_if.RW), 64'd3);
    idle();

    // Both sources continuously valid, then drain.
    mi = 0; ai = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 5'(1 + mi), 32'h1000_0000 + 32'(mi),
           1'b1, 5'(10 + ai), 32'h2000_0000 + 32'(ai), ma, aa);
      if (ma) mi++;
      if (aa) ai++;
    end
    for (int k = 0; k < 10 && mc > 0; k++) idle();
    idle();
    check("t36_drained", 64'(wb_if.count), 64'd0);

    // Reset mid-operation with three entries queued.
    step(1'b1, 5'd7, 32'h70, 1'b1, 5'd8, 32'h80, ma, aa);
    step(1'b1, 5'd9, 32'h90, 1'b1, 5'd10, 32'hA0, ma, aa);
    wb_if.mem_valid = 1'b0;
    wb_if.alu_valid = 1'b0;
    check("t37_count3", 64'(wb_if.count), 64'd3);
    #3 reset = 1'b1;
    #1;
    check("t37_count0", 64'(wb_if.count), 64'd0);
    check("t37_LE0", 64'(wb_if.LE), 64'd0);
    #2 reset = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    check("t37_post_LE", 64'(wb_if.LE), 64'd0);
    for (int k = 0; k < 4; k++) idle();

    // ALU write to register 0.
    wb_if.alu_valid = 1'b1;
    wb_if.alu_rd    = 5'd0;
    wb_if.alu_data  = 32'h5;
    #1;
    check("t38_ready", 64'(wb_if.alu_ready), 64'd1);
    @(posedge clk);
    #1;
    wb_if.alu_valid = 1'b0;
`ifdef REGFILE_WB_G0_DROP_EN
    check("t38_count", 64'(wb_if.count), 64'd0);
    @(posedge clk);
    #1;
    check("t38_LE", 64'(wb_if.LE), 64'd0);
    check("t38_count2", 64'(wb_if.count), 64'd0);
`else
    check("t38_count", 64'(wb_if.count), 64'd1);
    @(posedge clk);
    #1;
    check("t38_LE", 64'(wb_if.LE), 64'd1);
    check("t38_RW", 64'(wb_if.RW), 64'd0);
    check("t38_PW", 64'(wb_if.PW), 64'h5);
    last_rw = 5'd0;
    last_pw = 32'h5;
`endif
    idle();

    // Nine entries streamed back to back: pointers wrap twice.
    writes = 0;
    for (int k = 0; k < 9; k++)
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'(k + 1), 32'hC0DE_0000 + 32'(k), ma, aa);
    for (int k = 0; k < 10 && mc > 0; k++) idle();
    idle();
    check("t39_writes", 64'(writes), 64'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
